crc32_serial_sched: RTL and testbench

//   Two-requester scheduler in front of a bit-serial CRC-32 engine.
//   - Arbitrates round-robin between two word sources.
//   - Feeds the granted word MSB-first into the LFSR, one bit per clock.
//   - Emits {data, crc} with the source id on a valid/ready output port.
//   - Sits between frame builders and the serial link packer.

---
 rtl/crc32_pkg.sv | 12 +
 rtl/crc32_lfsr_bit.sv | 16 +
 rtl/crc32_serial_sched.sv | 65 ++++++
 tb/tb_crc32_serial_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// crc32_pkg: CRC-32 constants and scheduler state encoding; CRC32_STD_INIT_EN selects init/xorout 0xFFFFFFFF
package crc32_pkg;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
`ifdef CRC32_STD_INIT_EN
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
`else
  localparam logic [31:0] CRC32_INIT   = 32'h00000000;
  localparam logic [31:0] CRC32_XOROUT = 32'h00000000;
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/crc32_lfsr_bit.sv
// crc32_lfsr_bit: bit-serial CRC-32 LFSR; ports clk, rst (async active-low), load (to init, wins), en (shift din), crc
module crc32_lfsr_bit
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic        din,
  output logic [31:0] crc
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) crc <= CRC32_INIT;
    else if (load) crc <= CRC32_INIT;
    else if (en) crc <= {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CRC32_POLY : 32'h0);
endmodule

// File: rtl/crc32_serial_sched.sv
// crc32_serial_sched: round-robin two-requester scheduler feeding a bit-serial CRC-32 (CRC32_STD_INIT_EN selects init/xorout); ports req_valid/req_data0/req_data1/req_ready in, out_valid/out_ready/out_data/out_src out, busy
module crc32_serial_sched
  import crc32_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [DATA_W-1:0]   req_data0,
  input  logic [DATA_W-1:0]   req_data1,
  output logic [1:0]          req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W+31:0]  out_data,
  output logic                out_src,
  output logic                busy
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state, nxt;
  logic rr_ptr, g, accept, src;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sr;
  logic [31:0] crc;
  assign g = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
  assign accept = (state == IDLE) && req_valid[g];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (accept ? SHIFT : IDLE) :
          state == SHIFT ? (cnt == '0 ? DONE : SHIFT) :
          state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    req_ready = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
    busy      = state != IDLE;
    out_valid = state == DONE;
    out_data  = out_valid ? {sr, crc ^ CRC32_XOROUT} : '0;
    out_src   = src;
  end
  // The payload register rotates rather than shifts, so after DATA_W bits it holds the original word again.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr <= 1'b0;
      src    <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
    end else if (accept) begin
      rr_ptr <= ~g;
      src    <= g;
      cnt    <= CW'(DATA_W - 1);
      sr     <= g ? req_data1 : req_data0;
    end else if (state == SHIFT) begin
      cnt <= cnt - CW'(1);
      sr  <= DATA_W'({sr, sr[DATA_W-1]});
    end
  crc32_lfsr_bit u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state == SHIFT),
    .din  (sr[DATA_W-1]),
    .crc  (crc)
  );
endmodule

// File: tb/tb_crc32_serial_sched.sv
// tb_crc32_serial_sched: randomized and directed self-checking bench against a transaction-level model
module tb_crc32_serial_sched;
  localparam int W = 5;
`ifdef CRC32_STD_INIT_EN
  localparam logic [31:0] M_INIT = 32'hFFFFFFFF, M_XOR = 32'hFFFFFFFF;
`else
  localparam logic [31:0] M_INIT = 32'h0, M_XOR = 32'h0;
`endif
  logic clk = 0, rst = 1, out_ready = 0, out_valid, out_src, busy;
  logic [1:0] req_valid = 0, req_ready;
  logic [W-1:0] d0 = 0, d1 = 0;
  logic [W+31:0] out_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  crc32_serial_sched #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .busy(busy)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // Remainder of ((init * x^W) + data) * x^32 modulo G, by polynomial long division.
  function automatic logic [31:0] ref_crc(input logic [W-1:0] d);
    logic [95:0] v;
    v = ((96'(M_INIT) << W) ^ 96'(d)) << 32;
    for (int i = 95; i >= 32; i--)
      if (v[i]) v ^= 96'h1_04C11DB7 << (i - 32);
    return v[31:0] ^ M_XOR;
  endfunction
  logic m_rr = 0, m_src = 0;
  int m_ph = 0, m_t = 0;
  logic [W-1:0] m_pl = 0;
  function automatic logic m_grant(input logic [1:0] rv, input logic rr);
    return rv == 2'b11 ? rr : rv[1];
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_ph = 0; m_rr = 0; m_t = 0;
    end else if (m_ph == 0) begin
      if (|req_valid) begin
        m_src = m_grant(req_valid, m_rr);
        m_pl  = m_src ? d1 : d0;
        m_rr  = ~m_src;
        m_t   = W;
        m_ph  = 1;
      end
    end else if (m_ph == 1) begin
      m_t--;
      if (m_t == 0) m_ph = 2;
    end else if (out_ready) m_ph = 0;
  always @(negedge clk)
    if (rst) begin
      chk("req_ready", req_ready, (m_ph == 0 && |req_valid) ? (m_grant(req_valid, m_rr) ? 2'b10 : 2'b01) : 2'b00);
      chk("busy", busy, m_ph != 0);
      chk("out_valid", out_valid, m_ph == 2);
      if (m_ph == 2) begin
        chk("out_data", out_data, {m_pl, ref_crc(m_pl)});
        chk("out_src", out_src, m_src);
      end
    end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic wait_accept(output logic s);
    s = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        s = req_ready[1];
        return;
      end
    end
    chk("accept_timeout", 1, 0);
  endtask
  task automatic wait_valid(output int k);
    for (k = 1; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    chk("valid_timeout", 1, 0);
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    step();
  endtask
  initial begin
    logic s;
    int k;
    logic [W+31:0] held;
    logic [W-1:0] pl;
`ifndef CRC32_STD_INIT_EN
    chk("model_11001", ref_crc(5'b11001), 32'h6ED82B7F);
    chk("model_00001", ref_crc(5'b00001), 32'h04C11DB7);
    chk("model_00000", ref_crc(5'b00000), 32'h00000000);
`endif
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    rst = 1;
    step();
    // Directed words: latency counted from the start of the accepting IDLE cycle.
    for (int t = 0; t < 3; t++) begin
      pl = t == 0 ? 5'b11001 : t == 1 ? 5'b00001 : 5'b00000;
      out_ready = 1;
      if (t == 1) begin d1 = pl; req_valid = 2'b10; end
      else begin d0 = pl; req_valid = 2'b01; end
      wait_accept(s);
      step();
      req_valid = 0;
      wait_valid(k);
      chk("latency", k, W + 1);
      chk("src", out_src, t == 1);
`ifndef CRC32_STD_INIT_EN
      chk("lit_data", out_data, {pl, t == 0 ? 32'h6ED82B7F : t == 1 ? 32'h04C11DB7 : 32'h0});
`endif
      step();
    end
    do_reset();
    req_valid = 2'b11; d0 = 5'h0A; d1 = 5'h15;
    for (int n = 0; n < 4; n++) begin
      wait_accept(s);
      chk("rr_order", s, n % 2);
      step();
    end
    req_valid = 0;
    repeat (W + 3) step();
    out_ready = 0;
    req_valid = 2'b11;
    wait_accept(s);
    wait_valid(k);
    held = out_data;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_data", out_data, held);
      chk("stall_src", out_src, s);
      chk("stall_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    step();
    out_ready = 1;
    wait_accept(s);
    chk("post_stall_grant", s, 1);
    step();
    req_valid = 0;
    repeat (W + 3) step();
    d0 = 5'h1F; req_valid = 2'b01;
    wait_accept(s);
    step();
    req_valid = 0;
    repeat (2) @(negedge clk);
    chk("mid_shift_busy", busy, 1);
    do_reset();
    d1 = 5'h13; req_valid = 2'b10;
    wait_accept(s);
    step();
    req_valid = 0;
    wait_valid(k);
    chk("after_rst_data", out_data, {5'h13, ref_crc(5'h13)});
    step();
    for (int n = 0; n < 600; n++) begin
      req_valid = 2'($urandom);
      d0 = W'($urandom);
      d1 = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
